div_rem_unit: RTL and testbench
===============================

Name: div_rem_unit

Overview:
- Iterative RV32M divide/remainder unit for DIV, DIVU, REM and REMU.
- Sits directly downstream of register_file: it takes the rd1_o/rd2_o operand pair as its inputs.
- Its result goes to the writeback mux and is written back through register_file's reg_write_data_i.
- busy_o stalls the core while a divide is in flight.

Parameters:
- XLEN, 32, operand and result width; the iteration count equals XLEN.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- start_i  input  1  begin an operation; sampled only in IDLE.
- op_i  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- rs1_data_i  input  XLEN  dividend, from register_file rd1_o.
- rs2_data_i  input  XLEN  divisor, from register_file rd2_o.
- flush_i  input  1  synchronous abort of the in-flight operation.
- busy_o  output  1  high whenever state is not IDLE.
- done_o  output  1  one-cycle pulse; result_o is valid while it is high.
- result_o  output  XLEN  quotient or remainder, held until the next accepted start.

Behaviour:
- Reset (rst_i low, asynchronous):
  - state = IDLE; busy_o = 0, done_o = 0, result_o = 0.
  - Internal remainder, quotient and counter cleared.
  - Reset mid-operation abandons the operation immediately, with no done pulse.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE:
  - On an edge with start_i = 1, latch op_i, rs1_data_i and rs2_data_i.
  - Later changes on the input ports are ignored until the next IDLE.
  - Special case, divisor == 0:
    - result_o = all ones for DIV/DIVU; result_o = dividend for REM/REMU.
    - Next state DONE.
  - Special case, signed overflow (DIV/REM, dividend = 0x80000000, divisor = 0xFFFFFFFF):
    - result_o = 0x80000000 for DIV, 0 for REM.
    - Next state DONE.
  - Otherwise:
    - Signed ops: record the quotient sign (sign1 XOR sign2) and the remainder sign (sign1).
    - Load the magnitudes |rs1|, |rs2|; unsigned ops load the operands unchanged.
    - Counter = 0; next state CALC.
- CALC:
  - One restoring-division step per cycle:
    - Shift {rem, quo} left by 1.
    - Trial subtract the divisor from rem; if it does not underflow, keep the difference and set quo[0] = 1.
  - The remainder datapath is XLEN+1 bits wide so the trial subtract cannot overflow.
  - After XLEN steps (counter = XLEN-1 on the last step) go to FIX.
- FIX:
  - Apply the recorded sign by two's-complement negation if needed.
  - Select quotient (DIV/DIVU) or remainder (REM/REMU) into result_o; go to DONE.
- DONE:
  - done_o = 1 for exactly this cycle; next edge returns to IDLE.
  - start_i is not accepted in DONE; it is first sampled on the edge after IDLE is re-entered.
- Latency, counting the start edge as E0:
  - Normal operation: done_o high in the cycle after edge E(XLEN+1), i.e. 33 cycles for XLEN = 32.
  - Special cases: done_o high in the cycle right after E0 (1 cycle).
- busy_o is high in CALC, FIX and DONE; it is low the cycle after done_o falls.
- start_i while busy: ignored, with no effect on the current operation.
- flush_i:
  - In CALC or FIX: go to IDLE on the next edge; no done pulse; result_o keeps its previous value.
  - In DONE: the done pulse completes unchanged.
  - If flush_i and start_i are both high in IDLE, flush wins and nothing starts.
- Result sign rules:
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - A zero result is never negated to a nonzero value.

Test Plan:
- DIVU 100 / 7, start at E0 → busy_o high E0..E33; done_o pulse exactly once, 33 cycles after start; result_o = 14 (0x0000000E). REMU with the same operands → 2.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD (−3). REM with the same operands → 0xFFFFFFFF (−1). REM 7 / 0xFFFFFFFE (−2) → 1.
- Divide by zero: DIV 5/0 → 0xFFFFFFFF and REMU 5/0 → 5, each with done_o one cycle after start; DIVU 0/0 → 0xFFFFFFFF.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM with the same operands → 0, 1-cycle latency.
- Abort and restart:
  - Assert flush_i 10 cycles into DIVU 1000/3 → busy_o low next cycle, no done_o, result_o unchanged.
  - An immediate new start of DIVU 9/3 → 3.
  - start_i toggled mid-operation changes nothing.
- Reset mid-operation: drive rst_i low at cycle 15 of a DIV, asynchronously between clock edges → busy_o, done_o and result_o go to 0 without waiting for a clock edge. After release, DIVU 0xFFFFFFFF / 1 → 0xFFFFFFFF.

Source files
------------

// File: rtl/div_rem_unit_if.sv
// Request/response bundle between the issuing core and div_rem_unit.
// The core drives the operands and control signals; the divider returns
// the busy/done status and the result.
interface div_rem_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            start_i;
    logic [1:0]      op_i;
    logic [XLEN-1:0] rs1_data_i;
    logic [XLEN-1:0] rs2_data_i;
    logic            flush_i;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;

    modport master (
        output start_i, op_i, rs1_data_i, rs2_data_i, flush_i,
        input  busy_o, done_o, result_o
    );

    modport slave (
        input  start_i, op_i, rs1_data_i, rs2_data_i, flush_i,
        output busy_o, done_o, result_o
    );
endinterface

// File: rtl/div_rem_unit.sv
// Iterative RV32M divide/remainder unit (DIV, DIVU, REM, REMU).
// Uses one restoring-division step per cycle on operand magnitudes, then
// applies the recorded signs. Divide-by-zero and signed overflow are
// resolved straight from IDLE without iterating.
module div_rem_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    div_rem_unit_if.slave bus
);
    localparam int unsigned CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t          state;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] dvs;
    logic [CW-1:0]   cnt;
    logic            is_rem;
    logic            q_neg;
    logic            r_neg;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    logic            op_signed;
    logic            op_rem;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div_zero;
    logic            ovf;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;
    logic            fits;
    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;

    assign bus.busy_o   = busy;
    assign bus.done_o   = done;
    assign bus.result_o = result;

    // Operand decode, special-case detection, one division step and sign fix-up.
    always_comb begin
        op_signed = ~bus.op_i[0];
        op_rem    = bus.op_i[1];
        a_neg     = op_signed & bus.rs1_data_i[XLEN-1];
        b_neg     = op_signed & bus.rs2_data_i[XLEN-1];
        a_mag     = a_neg ? -bus.rs1_data_i : bus.rs1_data_i;
        b_mag     = b_neg ? -bus.rs2_data_i : bus.rs2_data_i;
        div_zero  = (bus.rs2_data_i == '0);
        ovf       = op_signed && (bus.rs1_data_i == MIN_NEG) && (bus.rs2_data_i == '1);
        shifted   = {rem, quo[XLEN-1]};
        diff      = shifted - {1'b0, dvs};
        fits      = ~diff[XLEN];
        q_fix     = q_neg ? -quo : quo;
        r_fix     = r_neg ? -rem : rem;
    end

    // Control FSM with registered status/result outputs and the iteration datapath.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state  <= IDLE;
            rem    <= '0;
            quo    <= '0;
            dvs    <= '0;
            cnt    <= '0;
            is_rem <= 1'b0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start_i && !bus.flush_i) begin
                        is_rem <= op_rem;
                        busy   <= 1'b1;
                        if (div_zero) begin
                            result <= op_rem ? bus.rs1_data_i : '1;
                            done   <= 1'b1;
                            state  <= DONE;
                        end else if (ovf) begin
                            result <= op_rem ? '0 : MIN_NEG;
                            done   <= 1'b1;
                            state  <= DONE;
                        end else begin
                            q_neg <= a_neg ^ b_neg;
                            r_neg <= a_neg;
                            rem   <= '0;
                            quo   <= a_mag;
                            dvs   <= b_mag;
                            cnt   <= '0;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (bus.flush_i) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        rem <= fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
                        quo <= {quo[XLEN-2:0], fits};
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            state <= FIX;
                        end
                    end
                end
                FIX: begin
                    if (bus.flush_i) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        result <= is_rem ? r_fix : q_fix;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div_rem_unit.sv
// Directed self-checking bench for div_rem_unit: arithmetic results,
// latency, special cases, flush, start-while-busy and asynchronous reset.
module tb_div_rem_unit;
    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [31:0] sb[$];
    logic [31:0] last_result;

    div_rem_unit_if #(.XLEN(32)) bus ();

    div_rem_unit #(.XLEN(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one operation, wait for done within a bounded number of edges,
    // and check latency, result (via scoreboard) and return to idle.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp,
                          input int exp_edges, input bit noise);
        int edges;
        bit seen;
        logic [31:0] want;
        @(negedge clk);
        bus.start_i    = 1'b1;
        bus.op_i       = op;
        bus.rs1_data_i = a;
        bus.rs2_data_i = b;
        sb.push_back(exp);
        @(posedge clk);
        #1;
        bus.start_i    = 1'b0;
        bus.op_i       = 2'($urandom);
        bus.rs1_data_i = $urandom;
        bus.rs2_data_i = $urandom;
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 100) begin
            @(negedge clk);
            if (bus.done_o) begin
                seen = 1'b1;
            end else begin
                check({tag, " busy"}, 32'(bus.busy_o), 32'd1);
                if (noise && edges < 25) begin
                    bus.start_i    = edges[0];
                    bus.op_i       = 2'($urandom);
                    bus.rs1_data_i = $urandom;
                    bus.rs2_data_i = $urandom;
                end else begin
                    bus.start_i = 1'b0;
                end
                @(posedge clk);
                edges++;
            end
        end
        bus.start_i = 1'b0;
        check({tag, " latency"}, 32'(edges), 32'(exp_edges));
        want = sb.pop_front();
        check({tag, " result"}, bus.result_o, want);
        check({tag, " busy_at_done"}, 32'(bus.busy_o), 32'd1);
        last_result = want;
        @(negedge clk);
        check({tag, " done_once"}, 32'(bus.done_o), 32'd0);
        check({tag, " idle_after"}, 32'(bus.busy_o), 32'd0);
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        last_result    = '0;
        rst            = 1'b0;
        bus.start_i    = 1'b0;
        bus.op_i       = 2'b00;
        bus.rs1_data_i = '0;
        bus.rs2_data_i = '0;
        bus.flush_i    = 1'b0;

        repeat (2) @(negedge clk);
        check("reset busy", 32'(bus.busy_o), 32'd0);
        check("reset done", 32'(bus.done_o), 32'd0);
        check("reset result", bus.result_o, 32'd0);
        rst = 1'b1;

        run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 33, 1'b0);
        run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 33, 1'b0);
        run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 1'b0);
        run_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 1'b0);
        run_op("rem_7_m2", OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, 1'b0);
        run_op("div_m100_7", OP_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 33, 1'b0);
        run_op("rem_m100_7", OP_REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 33, 1'b0);
        run_op("rem_m14_7", OP_REM, 32'hFFFF_FFF2, 32'd7, 32'd0, 33, 1'b0);
        run_op("remu_big_16", OP_REMU, 32'hFFFF_FFFF, 32'd16, 32'd15, 33, 1'b0);
        run_op("div_5_0", OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 0, 1'b0);
        run_op("remu_5_0", OP_REMU, 32'd5, 32'd0, 32'd5, 0, 1'b0);
        run_op("divu_0_0", OP_DIVU, 32'd0, 32'd0, 32'hFFFF_FFFF, 0, 1'b0);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 1'b0);
        run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, 1'b0);
        run_op("divu_noise", OP_DIVU, 32'd12345, 32'd100, 32'd123, 33, 1'b1);

        // Flush ten cycles into DIVU 1000/3.
        @(negedge clk);
        bus.start_i    = 1'b1;
        bus.op_i       = OP_DIVU;
        bus.rs1_data_i = 32'd1000;
        bus.rs2_data_i = 32'd3;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        bus.flush_i = 1'b1;
        @(posedge clk);
        #1;
        bus.flush_i = 1'b0;
        @(negedge clk);
        check("flush busy", 32'(bus.busy_o), 32'd0);
        check("flush result_held", bus.result_o, last_result);
        for (int i = 0; i < 5; i++) begin
            check("flush no_done", 32'(bus.done_o), 32'd0);
            @(negedge clk);
        end

        run_op("divu_9_3_noise", OP_DIVU, 32'd9, 32'd3, 32'd3, 33, 1'b1);

        // Flush and start together in IDLE: nothing starts.
        @(negedge clk);
        bus.start_i    = 1'b1;
        bus.flush_i    = 1'b1;
        bus.op_i       = OP_DIVU;
        bus.rs1_data_i = 32'd50;
        bus.rs2_data_i = 32'd5;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        bus.flush_i = 1'b0;
        @(negedge clk);
        check("flush_wins busy", 32'(bus.busy_o), 32'd0);
        check("flush_wins result", bus.result_o, last_result);

        // Asynchronous reset fifteen cycles into a DIV.
        @(negedge clk);
        bus.start_i    = 1'b1;
        bus.op_i       = OP_DIV;
        bus.rs1_data_i = 32'hFFFF_FFCE;
        bus.rs2_data_i = 32'd3;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        repeat (14) @(posedge clk);
        #2;
        check("pre_reset busy", 32'(bus.busy_o), 32'd1);
        rst = 1'b0;
        #1;
        check("async_reset busy", 32'(bus.busy_o), 32'd0);
        check("async_reset done", 32'(bus.done_o), 32'd0);
        check("async_reset result", bus.result_o, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        run_op("divu_max_1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
